// File: rtl/ledg_pwm_driver_if.sv
// Avalon-MM slave bus for the green-LED PWM/blink conditioner.
interface ledg_pwm_driver_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/ledg_pwm_driver.sv
// Green-LED output conditioner: global PWM dimming plus optional per-LED blinking.
// Blink logic and its registers are built only when LEDG_BLINK_EN is defined.
module ledg_pwm_driver #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned PRESCALE = 50,
  parameter int unsigned BLINK_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_pattern,
  ledg_pwm_driver_if.slave    avs,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]     ps_q, ps_d;
  logic [7:0]          pwm_cnt_q, pwm_cnt_d;
  logic [7:0]          duty_q, duty_d;
  logic [7:0]          duty_sh_q, duty_sh_d;
  logic                enable_q, enable_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [NUM_LEDS-1:0] blank;
  logic                wr_en, tick, frame_end, pwm_on;
  logic                unused_wdata;

  assign wr_en        = avs.chipselect && !avs.write_n;
  assign unused_wdata = ^avs.writedata;

  // Shadow duty only moves on frame_end, so a mid-frame DUTY write cannot glitch the frame.
  always_comb begin
    tick      = (ps_q == PS_W'(PRESCALE - 1));
    frame_end = tick && (pwm_cnt_q == 8'hFF);
    ps_d      = tick ? '0 : ps_q + PS_W'(1);
    pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    duty_sh_d = frame_end ? duty_q : duty_sh_q;
    pwm_on    = (duty_sh_q == 8'hFF) || (pwm_cnt_q < duty_sh_q);
    enable_d  = enable_q;
    duty_d    = duty_q;
    if (wr_en && avs.address == 2'd0) enable_d = avs.writedata[0];
    if (wr_en && avs.address == 2'd1) duty_d   = avs.writedata[7:0];
    led_d = enable_q ? (led_pattern & {NUM_LEDS{pwm_on}} & ~blank) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_q      <= '0;
      pwm_cnt_q <= '0;
      duty_q    <= 8'hFF;
      duty_sh_q <= 8'hFF;
      enable_q  <= 1'b1;
      led_q     <= '0;
    end else begin
      ps_q      <= ps_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      duty_sh_q <= duty_sh_d;
      enable_q  <= enable_d;
      led_q     <= led_d;
    end
  end

  assign led_out = led_q;

`ifdef LEDG_BLINK_EN
  logic [NUM_LEDS-1:0] mask_q, mask_d;
  logic [BLINK_W-1:0]  half_q, half_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_ph_q, blink_ph_d;

  // A BLINK_HALF write restarts the blink cycle and wins over a coincident frame_end.
  always_comb begin
    mask_d      = mask_q;
    half_d      = half_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (wr_en && avs.address == 2'd2) mask_d = avs.writedata[NUM_LEDS-1:0];
    if (wr_en && avs.address == 2'd3) begin
      half_d      = avs.writedata[BLINK_W-1:0];
      blink_cnt_d = '0;
      blink_ph_d  = 1'b1;
    end else if (half_q == '0) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b1;
    end else if (frame_end) begin
      if (blink_cnt_q == half_q - BLINK_W'(1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q      <= '0;
      half_q      <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
    end else begin
      mask_q      <= mask_d;
      half_q      <= half_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  assign blank = mask_q & {NUM_LEDS{~blink_ph_q}};

  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      2'd0: avs.readdata = {31'd0, enable_q};
      2'd1: avs.readdata = {24'd0, duty_q};
      2'd2: avs.readdata = 32'(mask_q);
      2'd3: avs.readdata = 32'(half_q);
      default: avs.readdata = '0;
    endcase
  end
`else
  assign blank = '0;

  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      2'd0: avs.readdata = {31'd0, enable_q};
      2'd1: avs.readdata = {24'd0, duty_q};
      default: avs.readdata = '0;
    endcase
  end
`endif

endmodule
